hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline-control counterpart to the forwarding unit. The forwarding unit reads producer registers in M/W to steer operands in E; this block writes the control side.
- Generates stall and flush signals for the 5-stage RISC-V core (F/D/E/M/W): load-use stalls, taken-branch flushes and data-memory busy freezes.
- Keeps a per-register scoreboard of in-flight destination writes, a memory-busy timeout watchdog and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16: consecutive MemBusyM cycles after which mem_timeout is raised.
- CNT_W, 32: width of stall_cycles counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- Rs1_D  in  5  source reg 1 of instruction in D
- Rs2_D  in  5  source reg 2 of instruction in D
- RD_D  in  5  destination of instruction in D
- RegWriteD  in  1  D instruction writes RD_D
- RD_E  in  5  destination of instruction in E
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  branch/jump taken, resolved in E
- MemBusyM  in  1  data memory not ready for the access in M
- RD_W  in  5  destination in W
- RegWriteW  in  1  W instruction writes RD_W
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- StallM  out  1  hold EX/MEM register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register
- FlushW  out  1  clear MEM/WB register (bubble)
- pending_mask  out  32  bit r = 1 while register r has an in-flight write
- mem_timeout  out  1  sticky watchdog flag
- stall_cycles  out  CNT_W  count of cycles with StallF = 1

Behaviour:
- Control outputs are combinational, same cycle:
  - lwStall = ResultSrcE0 & (RD_E != 0) & ((Rs1_D == RD_E) | (Rs2_D == RD_E))
  - memFreeze = MemBusyM
  - StallM = StallE = memFreeze
  - StallF = StallD = lwStall | memFreeze
  - FlushD = PCSrcE & ~memFreeze
  - FlushE = (lwStall | PCSrcE) & ~memFreeze
  - FlushW = memFreeze
- memFreeze has priority. While it is high, no flush is issued; the pending flush is re-evaluated the cycle MemBusyM drops, because E still holds the branch.
- Scoreboard: 32 two-bit counters, cnt[0] hardwired to 0.
  - enter = RegWriteD & (RD_D != 0) & ~StallD & ~FlushE
  - commit = RegWriteW & (RD_W != 0) & ~FlushW
  - On a clk edge: enter alone increments cnt[RD_D]; commit alone decrements cnt[RD_W]. If both target the same register, that counter is unchanged.
  - pending_mask[r] = (cnt[r] != 0). Registered, so it updates on the edge.
  - A counter saturates at 3 and at 0. Overflow or underflow is an illegal sequence; handling is under Optional Feature.
- Watchdog: busy_cnt increments while MemBusyM and clears when it is low.
  - mem_timeout is set on the edge where busy_cnt reaches MEM_TIMEOUT-1 with MemBusyM still high, i.e. after MEM_TIMEOUT busy cycles.
  - mem_timeout stays set until rst.
  - busy_cnt saturates.
- stall_cycles increments on every edge with StallF = 1 and wraps at 2^CNT_W.
- Reset (async, any time, including mid-freeze):
  - all cnt = 0, so pending_mask = 0
  - busy_cnt = 0, mem_timeout = 0, stall_cycles = 0
  - Combinational outputs follow their inputs immediately.

Optional Feature:
- SCOREBOARD_CHECK_EN defined:
  - Adds output sb_error (1 bit, reset 0).
  - sb_error is sticky-set when an increment hits a counter already at 3, or a decrement hits a counter at 0.
  - Simulation also issues $error with the register index.
- Undefined: no port and no check logic; saturation only.

Test Plan:
- Load-use: ResultSrcE0=1, RD_E=5, Rs1_D=5 → StallF=StallD=FlushE=1, FlushD=0. Same with RD_E=0 → all 0.
- Taken branch: PCSrcE=1, no load → FlushD=FlushE=1, stalls 0. Same with MemBusyM=1 → StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0.
- Scoreboard:
  - RegWriteD=1, RD_D=7 for one advance → pending_mask=0x80 next cycle.
  - Later RegWriteW=1, RD_W=7 → 0x0.
  - Simultaneous enter and commit of r7 while at count 1 → stays 0x80.
  - RD_D=0 never sets a bit.
- Watchdog: MemBusyM high for 15 cycles → mem_timeout=0. High for 16 cycles → mem_timeout=1, and it stays 1 after MemBusyM drops.
- stall_cycles: 3 load-use cycles plus 4 busy cycles → stall_cycles=7.
- Reset: assert rst mid-freeze with pending_mask=0x80 and mem_timeout=1 → all three state registers read 0 with no clk edge needed. With SCOREBOARD_CHECK_EN, a W commit of r9 from empty → sb_error=1.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush control, in-flight write scoreboard, memory-busy watchdog and stall counter
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   Rs1_D, Rs2_D, RD_D       sources and destination of the instruction in D, RegWriteD its write enable
//   RD_E, ResultSrcE0        destination of the instruction in E and its is-load flag
//   PCSrcE                   branch/jump taken, resolved in E
//   MemBusyM                 data memory not ready for the access in M
//   RD_W, RegWriteW          destination and write enable of the instruction in W
//   StallF/D/E/M, FlushD/E/W pipeline register controls (combinational)
//   pending_mask             bit r set while register r has an in-flight write
//   mem_timeout              sticky flag, MemBusyM held for MEM_TIMEOUT cycles
//   stall_cycles             count of cycles with StallF set (wraps)
//   sb_error                 only with SCOREBOARD_CHECK_EN: sticky scoreboard overflow/underflow flag
module hazard_ctrl_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       RD_D,
  input  logic             RegWriteD,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemBusyM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [31:0]      pending_mask,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
`ifdef SCOREBOARD_CHECK_EN
  ,
  output logic             sb_error
`endif
);
  localparam int BW = $clog2(MEM_TIMEOUT + 1);
  logic lw_stall, mem_freeze, enter, commit;
  logic [31:0] inc_v, dec_v;
  logic [31:0][1:0] cnt_q, cnt_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  // A memory freeze holds E, so any flush is deferred until the branch is re-seen after the freeze.
  always_comb begin
    lw_stall = ResultSrcE0 && (RD_E != 5'd0) && ((Rs1_D == RD_E) || (Rs2_D == RD_E));
    mem_freeze = MemBusyM;
    StallM = mem_freeze;
    StallE = mem_freeze;
    StallF = lw_stall || mem_freeze;
    StallD = lw_stall || mem_freeze;
    FlushD = PCSrcE && !mem_freeze;
    FlushE = (lw_stall || PCSrcE) && !mem_freeze;
    FlushW = mem_freeze;
  end
  // Enter and commit on the same register cancel; otherwise each counter saturates at 0 and 3.
  always_comb begin
    enter = RegWriteD && (RD_D != 5'd0) && !StallD && !FlushE;
    commit = RegWriteW && (RD_W != 5'd0) && !FlushW;
    inc_v = enter ? (32'd1 << RD_D) : 32'd0;
    dec_v = commit ? (32'd1 << RD_W) : 32'd0;
    cnt_d = cnt_q;
    pending_mask = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = (inc_v[r] && !dec_v[r] && cnt_q[r] != 2'd3) ? cnt_q[r] + 2'd1 :
                 (dec_v[r] && !inc_v[r] && cnt_q[r] != 2'd0) ? cnt_q[r] - 2'd1 : cnt_q[r];
      pending_mask[r] = |cnt_q[r];
    end
    cnt_d[0] = 2'd0;
  end
  always_comb begin
    busy_cnt_d = !MemBusyM ? '0 : (busy_cnt_q == BW'(MEM_TIMEOUT)) ? busy_cnt_q : busy_cnt_q + BW'(1);
    mem_timeout_d = mem_timeout_q || (MemBusyM && busy_cnt_q == BW'(MEM_TIMEOUT - 1));
    stall_cycles_d = stall_cycles_q + CNT_W'(StallF);
  end
  assign mem_timeout = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
`ifdef SCOREBOARD_CHECK_EN
  logic [31:0] ovf_v, unf_v;
  logic sb_error_q, sb_error_d;
  always_comb begin
    ovf_v = '0;
    unf_v = '0;
    for (int r = 1; r < 32; r++) begin
      ovf_v[r] = inc_v[r] && !dec_v[r] && cnt_q[r] == 2'd3;
      unf_v[r] = dec_v[r] && !inc_v[r] && cnt_q[r] == 2'd0;
    end
    sb_error_d = sb_error_q || (|ovf_v) || (|unf_v);
  end
  assign sb_error = sb_error_q;
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst)
      for (int r = 1; r < 32; r++)
        if (ovf_v[r] || unf_v[r])
          $error("scoreboard %s on x%0d", ovf_v[r] ? "overflow" : "underflow", r);
  end
`endif
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      busy_cnt_q <= '0;
      mem_timeout_q <= 1'b0;
      stall_cycles_q <= '0;
`ifdef SCOREBOARD_CHECK_EN
      sb_error_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      busy_cnt_q <= busy_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
`ifdef SCOREBOARD_CHECK_EN
      sb_error_q <= sb_error_d;
`endif
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed and randomized checks of hazard_ctrl_unit against a behavioural model
module tb_hazard_ctrl_unit;
  localparam int MT = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] Rs1_D, Rs2_D, RD_D, RD_E, RD_W;
  logic RegWriteD, ResultSrcE0, PCSrcE, MemBusyM, RegWriteW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [31:0] pending_mask, stall_cycles;
`ifdef SCOREBOARD_CHECK_EN
  logic sb_error;
`endif
  int n_cmp = 0, n_err = 0;
  int m_cnt[32];
  int m_busy;
  bit m_to;
  bit [31:0] m_stall;

  hazard_ctrl_unit #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_D(RD_D), .RegWriteD(RegWriteD),
    .RD_E(RD_E), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
    .RD_W(RD_W), .RegWriteW(RegWriteW), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .pending_mask(pending_mask), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
`ifdef SCOREBOARD_CHECK_EN
    , .sb_error(sb_error)
`endif
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [6:0] exp_ctrl();
    bit lw, fz;
    lw = ResultSrcE0 && RD_E != 0 && (Rs1_D == RD_E || Rs2_D == RD_E);
    fz = MemBusyM;
    return {lw | fz, lw | fz, fz, fz, PCSrcE & !fz, (lw | PCSrcE) & !fz, fz};
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = (m_cnt[i] != 0);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_busy = 0;
    m_to = 0;
    m_stall = 0;
  endtask

  task automatic idle();
    {Rs1_D, Rs2_D, RD_D, RD_E, RD_W} = '0;
    {RegWriteD, ResultSrcE0, PCSrcE, MemBusyM, RegWriteW} = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic step();
    logic [6:0] c;
    bit en, cm;
    c = exp_ctrl();
    en = RegWriteD && RD_D != 0 && !c[5] && !c[1];
    cm = RegWriteW && RD_W != 0 && !c[0];
    if (!(en && cm && RD_D == RD_W)) begin
      if (en && m_cnt[RD_D] < 3) m_cnt[RD_D]++;
      if (cm && m_cnt[RD_W] > 0) m_cnt[RD_W]--;
    end
    if (MemBusyM) begin
      m_busy++;
      if (m_busy >= MT) m_to = 1;
    end else m_busy = 0;
    if (c[6]) m_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    n_cmp++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0) begin n_err++; $display("FAIL reset_ctrl: got %b expected 0000000", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}); end
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL reset_mask: got %h expected 0", pending_mask); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout); end
    n_cmp++; if (stall_cycles !== 32'h0) begin n_err++; $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_load_use();
    idle();
    ResultSrcE0 = 1; RD_E = 5; Rs1_D = 5;
    #1;
    n_cmp++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin n_err++; $display("FAIL load_use: got %b expected 1110", {StallF, StallD, FlushE, FlushD}); end
    RD_E = 0; Rs1_D = 0;
    #1;
    n_cmp++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0) begin n_err++; $display("FAIL load_use_x0: got %b expected 0000000", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}); end
    idle();
    step();
  endtask

  task automatic test_branch();
    idle();
    PCSrcE = 1;
    #1;
    n_cmp++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000110) begin n_err++; $display("FAIL branch: got %b expected 0000110", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}); end
    MemBusyM = 1;
    #1;
    n_cmp++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1111001) begin n_err++; $display("FAIL branch_frozen: got %b expected 1111001", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}); end
    idle();
    step();
  endtask

  task automatic test_scoreboard();
    idle(); RegWriteD = 1; RD_D = 7; step(); idle();
    n_cmp++; if (pending_mask !== 32'h80) begin n_err++; $display("FAIL sb_enter: got %h expected 00000080", pending_mask); end
    RegWriteD = 1; RD_D = 7; RegWriteW = 1; RD_W = 7; step(); idle();
    n_cmp++; if (pending_mask !== 32'h80) begin n_err++; $display("FAIL sb_same_reg: got %h expected 00000080", pending_mask); end
    RegWriteW = 1; RD_W = 7; step(); idle();
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL sb_commit: got %h expected 0", pending_mask); end
    RegWriteD = 1; RD_D = 0; step(); idle();
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL sb_x0: got %h expected 0", pending_mask); end
    RegWriteD = 1; RD_D = 3; MemBusyM = 1; step(); idle();
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL sb_stalled_enter: got %h expected 0", pending_mask); end
    RegWriteD = 1; RD_D = 3; PCSrcE = 1; step(); idle();
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL sb_flushed_enter: got %h expected 0", pending_mask); end
    step();
  endtask

  task automatic test_stall_cycles();
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    n_cmp++; if (stall_cycles !== 32'h0) begin n_err++; $display("FAIL stall_cnt_reset: got %0d expected 0", stall_cycles); end
    ResultSrcE0 = 1; RD_E = 4; Rs2_D = 4;
    repeat (3) step();
    idle(); MemBusyM = 1;
    repeat (4) step();
    idle();
    n_cmp++; if (stall_cycles !== 32'd7) begin n_err++; $display("FAIL stall_cnt: got %0d expected 7", stall_cycles); end
  endtask

  task automatic test_watchdog();
    idle(); step();
    MemBusyM = 1;
    repeat (MT - 1) step();
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL wd_15: got %b expected 0", mem_timeout); end
    step();
    n_cmp++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL wd_16: got %b expected 1", mem_timeout); end
    idle(); step();
    n_cmp++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL wd_sticky: got %b expected 1", mem_timeout); end
  endtask

  task automatic test_reset_mid_freeze();
    idle(); RegWriteD = 1; RD_D = 7; step(); idle();
    MemBusyM = 1;
    repeat (MT) step();
    n_cmp++; if ({pending_mask, mem_timeout} !== {32'h80, 1'b1}) begin n_err++; $display("FAIL pre_reset: got %h/%b expected 00000080/1", pending_mask, mem_timeout); end
    rst = 1'b1;
    #1;
    n_cmp++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL async_mask: got %h expected 0", pending_mask); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL async_timeout: got %b expected 0", mem_timeout); end
    n_cmp++; if (stall_cycles !== 32'h0) begin n_err++; $display("FAIL async_stall_cycles: got %0d expected 0", stall_cycles); end
    n_cmp++; if ({StallF, FlushW} !== 2'b11) begin n_err++; $display("FAIL async_comb: got %b expected 11", {StallF, FlushW}); end
    rst = 1'b0;
    model_reset();
    idle();
    step();
  endtask

`ifdef SCOREBOARD_CHECK_EN
  task automatic test_sb_check();
    idle();
    n_cmp++; if (sb_error !== 1'b0) begin n_err++; $display("FAIL sb_err_clear: got %b expected 0", sb_error); end
    RegWriteW = 1; RD_W = 9; step(); idle();
    n_cmp++; if (sb_error !== 1'b1) begin n_err++; $display("FAIL sb_err_underflow: got %b expected 1", sb_error); end
    rst = 1'b1; #1; rst = 1'b0; model_reset();
  endtask
`endif

  task automatic test_random();
    logic [6:0] c;
    for (int i = 0; i < 600; i++) begin
      Rs1_D = 5'($urandom_range(0, 7)); Rs2_D = 5'($urandom_range(0, 7));
      RD_D = 5'($urandom_range(0, 7)); RD_E = 5'($urandom_range(0, 7)); RD_W = 5'($urandom_range(0, 7));
      RegWriteD = 1'($urandom_range(0, 99) < 60); RegWriteW = 1'($urandom_range(0, 99) < 50);
      ResultSrcE0 = 1'($urandom_range(0, 99) < 40); PCSrcE = 1'($urandom_range(0, 99) < 20);
      MemBusyM = (i % 100 >= 70 && i % 100 < 88) ? 1'b1 : 1'($urandom_range(0, 99) < 15);
      #1;
      c = exp_ctrl();
      n_cmp++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== c) begin n_err++; $display("FAIL rnd_ctrl[%0d]: got %b expected %b", i, {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, c); end
      step();
      n_cmp++; if (pending_mask !== exp_mask()) begin n_err++; $display("FAIL rnd_mask[%0d]: got %h expected %h", i, pending_mask, exp_mask()); end
      n_cmp++; if (mem_timeout !== m_to) begin n_err++; $display("FAIL rnd_timeout[%0d]: got %b expected %b", i, mem_timeout, m_to); end
      n_cmp++; if (stall_cycles !== m_stall) begin n_err++; $display("FAIL rnd_stall_cycles[%0d]: got %0d expected %0d", i, stall_cycles, m_stall); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_scoreboard();
    test_stall_cycles();
    test_watchdog();
    test_reset_mid_freeze();
`ifdef SCOREBOARD_CHECK_EN
    test_sb_check();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
